// File: rtl/result_trace_fifo.sv
// result_trace_fifo: circular-buffer trace FIFO capturing ALU results with
// their flags and instruction number, drained through a valid/ready port.
// Optional feature macro: TRACE_DROP_CNT_EN enables a saturating counter of
// captures discarded while the FIFO is full; without it drop_cnt reads zero.
module result_trace_fifo #(
   parameter int DEPTH = 8,
   parameter int CW    = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   input  logic [31:0]   Result,
   input  logic [5:0]    InstructionNum,
   input  logic          Overflow,
   input  logic          Equal,
   input  logic          Carry,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [40:0]   out_data,
   output logic [CW-1:0] count,
   output logic          full,
   output logic          empty,
   output logic [7:0]    drop_cnt
);

   localparam int AW = $clog2(DEPTH);

   logic [40:0]   mem [DEPTH];
   logic [AW-1:0] wptr;
   logic [AW-1:0] rptr;
   logic [CW-1:0] cnt;
   logic          push;
   logic          pop;

   // Status flags come only from the registered occupancy.
   always_comb begin
      full      = (cnt == CW'(DEPTH));
      empty     = (cnt == '0);
      out_valid = ~empty;
      count     = cnt;
      out_data  = mem[rptr];
      pop       = out_valid & out_ready;
      // A pop in the same cycle frees a slot, so a full FIFO can still accept.
      push      = in_valid & (~full | pop);
   end

   // Entry storage; contents are left untouched by reset.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wptr] <= {InstructionNum, Overflow, Equal, Carry, Result};
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (push) wptr <= wptr + AW'(1);
         if (pop)  rptr <= rptr + AW'(1);
      end
   end

   // Occupancy: unchanged when push and pop coincide.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else begin
         case ({push, pop})
            2'b10:   cnt <= cnt + CW'(1);
            2'b01:   cnt <= cnt - CW'(1);
            default: cnt <= cnt;
         endcase
      end
   end

`ifdef TRACE_DROP_CNT_EN
   logic [7:0] drops;
   logic       drop;

   // A capture is lost only when full and nothing is popped that cycle.
   always_comb begin
      drop     = in_valid & full & ~pop;
      drop_cnt = drops;
   end

   // Saturating discard counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         drops <= '0;
      end else if (drop && (drops != 8'hFF)) begin
         drops <= drops + 8'd1;
      end
   end
`else
   assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_result_trace_fifo.sv
// tb_result_trace_fifo: table-driven, directed and randomized checks of
// result_trace_fifo against a queue-based reference model.
module tb_result_trace_fifo;

   localparam int DEPTH = 8;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic [31:0]   Result = '0;
   logic [5:0]    InstructionNum = '0;
   logic          Overflow = 1'b0;
   logic          Equal = 1'b0;
   logic          Carry = 1'b0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [40:0]   out_data;
   logic [CW-1:0] count;
   logic          full;
   logic          empty;
   logic [7:0]    drop_cnt;

   result_trace_fifo #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .Result(Result),
      .InstructionNum(InstructionNum), .Overflow(Overflow), .Equal(Equal),
      .Carry(Carry), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .count(count), .full(full), .empty(empty),
      .drop_cnt(drop_cnt)
   );

   always #5 clk = ~clk;

   // Reference model: ordered list of stored words plus discard tally.
   logic [40:0] q[$];
   int          m_drop = 0;
   int          n_cmp = 0;
   int          n_bad = 0;
   logic [40:0] last_popped;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Compare all outputs with the model, then advance one clock edge.
   task automatic step(input bit iv, input logic [31:0] res, input logic [5:0] pc,
                       input logic [2:0] fl, input bit rdy);
      bit          pop_m;
      bit          push_m;
      logic [40:0] w;
      in_valid = iv; Result = res; InstructionNum = pc;
      {Overflow, Equal, Carry} = fl; out_ready = rdy;
      chk("count", 64'(count), 64'(q.size()));
      chk("empty", 64'(empty), 64'(q.size() == 0));
      chk("full", 64'(full), 64'(q.size() == DEPTH));
      chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
      chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
      if (q.size() != 0) chk("out_data", 64'(out_data), 64'(q[0]));
      w      = {pc, fl, res};
      pop_m  = (q.size() != 0) && rdy;
      push_m = iv && ((q.size() < DEPTH) || pop_m);
      @(posedge clk);
      if (pop_m) last_popped = q.pop_front();
      if (push_m) q.push_back(w);
`ifdef TRACE_DROP_CNT_EN
      if (iv && !push_m && m_drop < 255) m_drop++;
`endif
      #1;
   endtask

   typedef struct {
      bit          iv;
      logic [31:0] res;
      logic [5:0]  pc;
      logic [2:0]  fl;
      bit          rdy;
      int          ecount;
      bit          evalid;
      logic [40:0] ehead;
   } vec_t;

   vec_t vt[6];

   initial begin
      vt[0] = '{1, 32'hDEADBEEF, 6'd5, 3'b101, 0, 1, 1, {6'd5, 3'b101, 32'hDEADBEEF}};
      vt[1] = '{1, 32'h11, 6'd1, 3'b000, 0, 2, 1, {6'd5, 3'b101, 32'hDEADBEEF}};
      vt[2] = '{0, 32'h0, 6'd0, 3'b000, 1, 1, 1, {6'd1, 3'b000, 32'h11}};
      vt[3] = '{1, 32'h22, 6'd2, 3'b010, 1, 1, 1, {6'd2, 3'b010, 32'h22}};
      vt[4] = '{0, 32'h0, 6'd0, 3'b000, 1, 0, 0, 41'h0};
      vt[5] = '{0, 32'h0, 6'd0, 3'b000, 1, 0, 0, 41'h0};

      // Reset state.
      #1;
      chk("rst_count", 64'(count), 0);
      chk("rst_empty", 64'(empty), 1);
      chk("rst_full", 64'(full), 0);
      chk("rst_valid", 64'(out_valid), 0);
      chk("rst_drop", 64'(drop_cnt), 0);
      #11 rst_n = 1'b1;

      // Table-driven directed vectors (first push on the first edge after reset).
      for (int i = 0; i < 6; i++) begin
         step(vt[i].iv, vt[i].res, vt[i].pc, vt[i].fl, vt[i].rdy);
         chk($sformatf("vec%0d_count", i), 64'(count), 64'(vt[i].ecount));
         chk($sformatf("vec%0d_valid", i), 64'(out_valid), 64'(vt[i].evalid));
         if (vt[i].evalid) chk($sformatf("vec%0d_head", i), 64'(out_data), 64'(vt[i].ehead));
      end

      // Fill to full, then drain in order.
      for (int i = 0; i < DEPTH; i++) step(1, 32'(i), 6'(i), 3'b000, 0);
      chk("fill_full", 64'(full), 1);
      chk("fill_count", 64'(count), DEPTH);
      for (int i = 0; i < DEPTH; i++) begin
         chk("drain_order", 64'(out_data[31:0]), 64'(i));
         step(0, 0, 0, 0, 1);
      end
      chk("drain_empty", 64'(empty), 1);

      // Discards while full leave contents alone.
      for (int i = 0; i < DEPTH; i++) step(1, 32'(100 + i), 6'(i), 3'b001, 0);
      for (int i = 0; i < 3; i++) step(1, 32'hBAD, 6'h3F, 3'b111, 0);
      chk("drop_count", 64'(count), DEPTH);
`ifdef TRACE_DROP_CNT_EN
      chk("drop_cnt3", 64'(drop_cnt), 3);
`else
      chk("drop_cnt3", 64'(drop_cnt), 0);
`endif
      chk("drop_head", 64'(out_data[31:0]), 100);

      // Push and pop together on a full FIFO.
      step(1, 32'h55, 6'd9, 3'b000, 1);
      chk("fullpp_count", 64'(count), DEPTH);
      chk("fullpp_head", 64'(out_data[31:0]), 101);
      for (int i = 0; i < DEPTH; i++) step(0, 0, 0, 0, 1);
      chk("fullpp_last", 64'(last_popped[31:0]), 32'h55);
      chk("fullpp_empty", 64'(empty), 1);

      // Streaming through one slot wraps the pointers.
      step(1, 32'd1000, 6'd0, 3'b000, 0);
      for (int k = 0; k < 20; k++) begin
         chk("stream_count", 64'(count), 1);
         chk("stream_head", 64'(out_data[31:0]), 64'(1000 + k));
         step(1, 32'(1001 + k), 6'(k), 3'b000, 1);
      end
      step(0, 0, 0, 0, 1);

      // Randomized traffic.
      for (int k = 0; k < 400; k++)
         step(1'($urandom_range(0, 1)), $urandom, 6'($urandom), 3'($urandom),
              1'($urandom_range(0, 3) == 0 ? 0 : ($urandom_range(0, 1))));

      // Long discard burst exercises counter saturation.
      for (int i = 0; i < DEPTH; i++) step(1, $urandom, 6'($urandom), 3'b000, 0);
      for (int i = 0; i < 260; i++) step(1, $urandom, 6'($urandom), 3'b000, 0);
`ifdef TRACE_DROP_CNT_EN
      chk("drop_sat", 64'(drop_cnt), 255);
`else
      chk("drop_sat", 64'(drop_cnt), 0);
`endif

      // Asynchronous reset with five entries held.
      for (int i = 0; i < DEPTH; i++) step(0, 0, 0, 0, 1);
      for (int i = 0; i < 5; i++) step(1, 32'(200 + i), 6'(i), 3'b000, 0);
      chk("pre_rst_count", 64'(count), 5);
      rst_n = 1'b0;
      #1;
      chk("arst_count", 64'(count), 0);
      chk("arst_valid", 64'(out_valid), 0);
      chk("arst_drop", 64'(drop_cnt), 0);
      q.delete();
      m_drop = 0;
      #1 rst_n = 1'b1;
      step(1, 32'hCAFE, 6'd7, 3'b100, 0);
      chk("post_rst_head", 64'(out_data), 64'({6'd7, 3'b100, 32'hCAFE}));
      chk("post_rst_count", 64'(count), 1);
      step(0, 0, 0, 0, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
